// File: rtl/accum_calc_engine.sv
// ---------------------------------------------------------------------------
// accum_calc_engine
//
// One matrix-vector pass of the iteration loop: v_new[i] = sum_j Y[i][j]*v_old[j]
// for all N rows. Y and v_old are streamed from single-cycle-latency SRAMs, one
// (i,j) pair per cycle. Each finished row is shifted back to the shared Q
// format, saturated and written into the V section opposite to the one being
// read. One done pulse ends the pass. The block then waits for enable to drop
// before it can be started again.
//
// Ports
//   clock                 rising-edge clock
//   reset                 asynchronous, active-high reset
//   in_enableAccumCalc    level enable from the iteration counter
//   in_vsramSection       V section holding v_old, sampled when a pass starts
//   op_ysram_addr         Y SRAM read address, {i, j}
//   ip_ysram_data         Y SRAM read data (valid one cycle after the address)
//   op_vsram_rd_addr      V SRAM read address, {sec, j}
//   ip_vsram_rd_data      V SRAM read data (valid one cycle after the address)
//   op_vsram_wr_en        V SRAM write strobe, one cycle per row
//   op_vsram_wr_addr      V SRAM write address, {~sec, i}
//   op_vsram_wr_data      saturated row result
//   op_accumCalcDoneFlag  one-cycle pulse after all N rows are written
// ---------------------------------------------------------------------------
module accum_calc_engine #(
    parameter int N      = 16,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_enableAccumCalc,
    input  logic                     in_vsramSection,
    output logic [2*$clog2(N)-1:0]   op_ysram_addr,
    input  logic [DATA_W-1:0]        ip_ysram_data,
    output logic [$clog2(N):0]       op_vsram_rd_addr,
    input  logic [DATA_W-1:0]        ip_vsram_rd_data,
    output logic                     op_vsram_wr_en,
    output logic [$clog2(N):0]       op_vsram_wr_addr,
    output logic [DATA_W-1:0]        op_vsram_wr_data,
    output logic                     op_accumCalcDoneFlag
);

    localparam int ADDR_W = $clog2(N);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_FLUSH    = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_WAIT_LOW = 3'd4;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N-1);

    // Control state
    logic [2:0]              state_q, state_d;
    logic                    sec_q, sec_d;
    logic [ADDR_W-1:0]       i_q, i_d;          // row of the pair being issued
    logic [ADDR_W-1:0]       j_q, j_d;          // column of the pair being issued
    logic                    flush_q, flush_d;  // second FLUSH cycle

    // Data stage: coordinates of the pair whose SRAM data is arriving now
    logic                    dv_q, dv_d;
    logic [ADDR_W-1:0]       di_q, di_d;
    logic [ADDR_W-1:0]       dj_q, dj_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    // Registered outputs
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W:0]         wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic                    done_q, done_d;

    // Datapath
    logic signed [DATA_W-1:0]   y_s, v_s;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    shifted;
    logic [DATA_W-1:0]          sat;
    logic                       issue_last;
    logic                       abort;

    assign y_s      = ip_ysram_data;
    assign v_s      = ip_vsram_rd_data;
    assign prod     = (2*DATA_W)'(y_s) * (2*DATA_W)'(v_s);
    assign prod_ext = ACC_W'(prod);
    // The last product of a row is folded in here so the write can be
    // registered in the same cycle the final operand pair arrives.
    assign sum      = acc_q + prod_ext;
    // Arithmetic shift floors toward -inf, matching plain truncation in Q format.
    assign shifted  = sum >>> FRAC_W;

    always_comb begin
        if (shifted > SAT_MAX) begin
            sat = DATA_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            sat = DATA_W'(SAT_MIN);
        end else begin
            sat = DATA_W'(shifted);
        end
    end

    assign issue_last = (i_q == LAST_IDX) && (j_q == LAST_IDX);
    assign abort      = ((state_q == S_RUN) || (state_q == S_FLUSH)) && !in_enableAccumCalc;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case/if tree can leave it unassigned and infer a latch.
        state_d   = state_q;
        sec_d     = sec_q;
        i_d       = i_q;
        j_d       = j_q;
        flush_d   = flush_q;
        dv_d      = 1'b0;
        di_d      = i_q;
        dj_d      = j_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        // Accumulate the pair whose data is on the SRAM read ports this cycle.
        if (dv_q) begin
            acc_d = (dj_q == '0) ? prod_ext : sum;
            if (dj_q == LAST_IDX) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {~sec_q, di_q};
                wr_data_d = sat;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_enableAccumCalc) begin
                    sec_d   = in_vsramSection;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!in_enableAccumCalc) begin
                    state_d = S_IDLE;
                end else begin
                    // The pair currently on the address bus is captured by the
                    // SRAMs at this edge; its data arrives next cycle.
                    dv_d = 1'b1;
                    if (issue_last) begin
                        flush_d = 1'b0;
                        state_d = S_FLUSH;
                    end else begin
                        // N is a power of two, so j wraps to 0 on its own.
                        j_d = j_q + ADDR_W'(1);
                        if (j_q == LAST_IDX) begin
                            i_d = i_q + ADDR_W'(1);
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!in_enableAccumCalc) begin
                    state_d = S_IDLE;
                end else if (flush_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!in_enableAccumCalc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An aborted pass drops its partial row and any pending write.
        if (abort) begin
            dv_d    = 1'b0;
            wr_en_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sec_q     <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            flush_q   <= 1'b0;
            dv_q      <= 1'b0;
            di_q      <= '0;
            dj_q      <= '0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            i_q       <= i_d;
            j_q       <= j_d;
            flush_q   <= flush_d;
            dv_q      <= dv_d;
            di_q      <= di_d;
            dj_q      <= dj_d;
            acc_q     <= acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Read addresses come straight from the issue counters, so they are
    // registered and hold their last value through FLUSH.
    assign op_ysram_addr        = {i_q, j_q};
    assign op_vsram_rd_addr     = {sec_q, j_q};
    assign op_vsram_wr_en       = wr_en_q;
    assign op_vsram_wr_addr     = wr_addr_q;
    assign op_vsram_wr_data     = wr_data_q;
    assign op_accumCalcDoneFlag = done_q;

endmodule

// File: tb/tb_accum_calc_engine.sv
// ---------------------------------------------------------------------------
// tb_accum_calc_engine
//
// Self-checking bench for accum_calc_engine with N=4. Behavioural SRAMs feed
// the DUT. Each pass is compared row by row against a golden matrix-vector
// product that uses plain integer arithmetic, with write timing, write
// addresses and done timing checked as well. Covers reset, identity,
// saturation in both directions, section ping-pong, mid-run reset, abort and
// random passes.
// ---------------------------------------------------------------------------
module tb_accum_calc_engine;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int AW = $clog2(N);

    logic              clock = 1'b0;
    logic              reset;
    logic              en;
    logic              sec_in;
    logic [2*AW-1:0]   y_addr;
    logic [DW-1:0]     y_data;
    logic [AW:0]       v_rd_addr;
    logic [DW-1:0]     v_rd_data;
    logic              wr_en;
    logic [AW:0]       wr_addr;
    logic [DW-1:0]     wr_data;
    logic              done;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_rec_t;

    wr_rec_t       wr_log[$];
    int            done_log[$];
    logic [DW-1:0] ymem [N*N];
    logic [DW-1:0] vmem [2*N];
    logic [DW-1:0] exp_row [N];
    int            cyc      = 0;
    int            start_x  = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    accum_calc_engine #(
        .N      (N),
        .DATA_W (DW),
        .FRAC_W (FW),
        .ACC_W  (40)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .in_enableAccumCalc   (en),
        .in_vsramSection      (sec_in),
        .op_ysram_addr        (y_addr),
        .ip_ysram_data        (y_data),
        .op_vsram_rd_addr     (v_rd_addr),
        .ip_vsram_rd_data     (v_rd_data),
        .op_vsram_wr_en       (wr_en),
        .op_vsram_wr_addr     (wr_addr),
        .op_vsram_wr_data     (wr_data),
        .op_accumCalcDoneFlag (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Read-only SRAM models with one cycle of latency.
    always @(posedge clock) begin
        y_data    <= ymem[y_addr];
        v_rd_data <= vmem[v_rd_addr];
    end

    // Log writes and done pulses with their cycle number relative to the
    // cycle in which enable was first presented.
    always @(negedge clock) begin
        if (!reset) begin
            if (wr_en) wr_log.push_back('{cyc - start_x, int'(wr_addr), int'(wr_data)});
            if (done)  done_log.push_back(cyc - start_x);
        end
    end

    task automatic check(input string tag, input longint got, input longint expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    endtask

    // Golden row: exact integer dot product, floor shift, clamp to DW bits.
    function automatic logic [DW-1:0] golden_row(input int i, input int s);
        longint sum = 0;
        for (int j = 0; j < N; j++) begin
            sum += longint'($signed(ymem[i*N+j])) * longint'($signed(vmem[s*N+j]));
        end
        sum = sum >>> FW;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum[DW-1:0];
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_yaddr"},  longint'(y_addr),    0);
        check({tag, "_vraddr"}, longint'(v_rd_addr), 0);
        check({tag, "_wren"},   longint'(wr_en),     0);
        check({tag, "_waddr"},  longint'(wr_addr),   0);
        check({tag, "_wdata"},  longint'(wr_data),   0);
        check({tag, "_done"},   longint'(done),      0);
    endtask

    // Called at a negedge: presents enable (cycle 0), then returns at the
    // negedge of cycle 1 with the section input flipped to prove it was latched.
    task automatic start_run(input int s);
        for (int i = 0; i < N; i++) exp_row[i] = golden_row(i, s);
        wr_log.delete();
        done_log.delete();
        sec_in  = s[0];
        en      = 1'b1;
        start_x = cyc;
        @(negedge clock);
        sec_in = ~s[0];
    endtask

    task automatic finish_run(input int s, input string tag);
        int n = 0;
        while (done_log.size() == 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_seen"}, longint'(done_log.size() > 0), 1);
        if (done_log.size() > 0) check({tag, "_done_cyc"}, done_log[0], N*N+3);
        // Enable held high after done must not restart the pass.
        repeat (3) @(negedge clock);
        check({tag, "_done_cnt"}, done_log.size(), 1);
        check({tag, "_wr_cnt"},   wr_log.size(),   N);
        for (int i = 0; i < N && i < wr_log.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), wr_log[i].addr, (1-s)*N + i);
            check($sformatf("%s_wdata%0d", tag, i), wr_log[i].data, int'(exp_row[i]));
            check($sformatf("%s_wcyc%0d",  tag, i), wr_log[i].cyc,  (i+1)*N + 2);
        end
        // Keep the SRAM image in step with what a correct pass leaves behind.
        for (int i = 0; i < N; i++) vmem[(1-s)*N + i] = exp_row[i];
        en = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N*N; k++) ymem[k] = DW'($urandom);
        for (int k = 0; k < 2*N; k++) vmem[k] = DW'($urandom);
    endtask

    initial begin
        logic [DW-1:0] v_init [N];
        reset  = 1'b1;
        en     = 1'b0;
        sec_in = 1'b0;
        for (int k = 0; k < N*N; k++) ymem[k] = '0;
        for (int k = 0; k < 2*N; k++) vmem[k] = '0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // 1: identity (1.0 in Q8) reproduces v_old in the other section
        v_init[0] = 16'd256;
        v_init[1] = -16'sd512;
        v_init[2] = 16'd768;
        v_init[3] = 16'd1024;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                ymem[i*N+j] = (i == j) ? 16'h0100 : 16'h0000;
        for (int i = 0; i < N; i++) vmem[i] = v_init[i];
        start_run(0);
        finish_run(0, "t1");
        for (int i = 0; i < N; i++) check($sformatf("t1_copy%0d", i), longint'(vmem[N+i]), longint'(v_init[i]));

        // 2: saturation, positive then negative
        for (int k = 0; k < N*N; k++) ymem[k] = 16'h7FFF;
        for (int i = 0; i < N; i++) vmem[i] = 16'h7FFF;
        start_run(0);
        finish_run(0, "t2pos");
        for (int i = 0; i < N; i++) vmem[i] = 16'h8000;
        start_run(0);
        finish_run(0, "t2neg");

        // 3: two iterations, section ping-pong
        fill_random();
        start_run(0);
        finish_run(0, "t3a");
        start_run(1);
        finish_run(1, "t3b");

        // 4: asynchronous reset mid-run, then restart with enable still high
        fill_random();
        start_run(0);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        #1;
        check_zero("t4_async");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        start_run(0);
        finish_run(0, "t4");

        // 5: abort during row 2, then a clean full pass
        fill_random();
        start_run(0);
        repeat (10) @(negedge clock);
        en = 1'b0;
        repeat (20) @(negedge clock);
        check("t5_abort_wr_cnt",   wr_log.size(),   2);
        check("t5_abort_done_cnt", done_log.size(), 0);
        check("t5_abort_wren",     longint'(wr_en), 0);
        for (int i = 0; i < 2 && i < wr_log.size(); i++)
            check($sformatf("t5_abort_wdata%0d", i), wr_log[i].data, int'(exp_row[i]));
        start_run(0);
        finish_run(0, "t5");

        // 6: random passes, alternating sections
        for (int r = 0; r < 10; r++) begin
            fill_random();
            start_run(r % 2);
            finish_run(r % 2, $sformatf("t6r%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
